// File: rtl/nn_bus_pkg.sv
// nn_bus_pkg: shared types and helpers for the NN accelerator Avalon-MM burst slave.
// Holds the slave FSM state enum, address region enum, Avalon response codes,
// CSR bit positions and the address-map helper functions that derive region
// bases from PIX_DEPTH / WGT_DEPTH / NUM_RES.
package nn_bus_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWburst,
        StRburst
    } bus_state_e;

    typedef enum logic [2:0] {
        RegionPix,
        RegionWgt,
        RegionRes,
        RegionCsr,
        RegionNone
    } region_e;

    localparam logic [1:0] RespOkay      = 2'b00;
    localparam logic [1:0] RespSlvErr    = 2'b10;
    localparam logic [1:0] RespDecodeErr = 2'b11;

    localparam int unsigned CsrStartBit = 0;
    localparam int unsigned CsrIrqEnBit = 1;
    localparam int unsigned CsrDoneBit  = 2;
    localparam int unsigned CsrBusyBit  = 3;

    function automatic int unsigned wgt_base(int unsigned pix_depth);
        return pix_depth;
    endfunction

    function automatic int unsigned res_base(int unsigned pix_depth, int unsigned wgt_depth);
        return pix_depth + wgt_depth;
    endfunction

    function automatic int unsigned csr_addr(int unsigned pix_depth, int unsigned wgt_depth,
                                             int unsigned num_res);
        return pix_depth + wgt_depth + num_res;
    endfunction

    function automatic region_e decode_region(int unsigned addr, int unsigned pix_depth,
                                              int unsigned wgt_depth, int unsigned num_res);
        if (addr < wgt_base(pix_depth)) begin
            return RegionPix;
        end else if (addr < res_base(pix_depth, wgt_depth)) begin
            return RegionWgt;
        end else if (addr < csr_addr(pix_depth, wgt_depth, num_res)) begin
            return RegionRes;
        end else if (addr == csr_addr(pix_depth, wgt_depth, num_res)) begin
            return RegionCsr;
        end else begin
            return RegionNone;
        end
    endfunction

endpackage

// File: rtl/avalon_burst_counter.sv
// avalon_burst_counter: burst bookkeeping shared by write and read bursts.
// Latches the burst base address and beat count (burstcount 0 is treated as 1),
// tracks the current beat index and flags the last beat.
// Ports:
//   clk, n_rst       clock, asynchronous active-low reset
//   load             latch load_base / load_beats this cycle
//   load_skip_first  start the index at 1 (beat 0 already performed on load)
//   load_base        burst base word address
//   load_beats       raw burstcount
//   step             advance to the next beat
//   beat_addr        base + index, wrapping modulo 2^ADDR_W
//   last_beat        current index is the final beat of the burst
module avalon_burst_counter
    import nn_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned BURST_W = 10
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               load,
    input  logic               load_skip_first,
    input  logic [ADDR_W-1:0]  load_base,
    input  logic [BURST_W-1:0] load_beats,
    input  logic               step,
    output logic [ADDR_W-1:0]  beat_addr,
    output logic               last_beat
);

    logic [ADDR_W-1:0]  base_q, base_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic [BURST_W-1:0] idx_q, idx_d;

    always_comb begin
        base_d  = base_q;
        beats_d = beats_q;
        idx_d   = idx_q;
        if (load) begin
            base_d  = load_base;
            beats_d = (load_beats == '0) ? BURST_W'(1) : load_beats;
            idx_d   = load_skip_first ? BURST_W'(1) : '0;
        end else if (step) begin
            idx_d = idx_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            base_q  <= '0;
            beats_q <= '0;
            idx_q   <= '0;
        end else begin
            base_q  <= base_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
        end
    end

    // Natural wrap of the ADDR_W-bit sum gives modulo-2^ADDR_W beat addresses.
    assign beat_addr = base_q + ADDR_W'(idx_q);
    assign last_beat = (idx_q == beats_q - BURST_W'(1));

endmodule

// File: rtl/avalon_burst_slave.sv
// avalon_burst_slave: Avalon-MM burst slave front end for the NN core.
// Address map (words): pixels, weights, read-only results, one CSR, then unmapped.
// Writes go out as registered single-cycle pix/wgt enables; reads return one beat
// per cycle while waitrequest holds off new commands.
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   address/write/read/...      Avalon-MM slave command side
//   readdata/readdatavalid/
//   response/waitrequest        Avalon-MM slave response side
//   pix_addr/pix_wen,
//   wgt_addr/wgt_wen,
//   store_data                  memory write port toward pixel/weight stores
//   res_sel/res_data            result word mux (combinational select -> data)
//   done_calc/start_calc/irq    core handshake and interrupt
module avalon_burst_slave
    import nn_bus_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned BURST_W   = 10,
    parameter int unsigned PIX_DEPTH = 784,
    parameter int unsigned WGT_DEPTH = 784,
    parameter int unsigned NUM_RES   = 10,
    parameter int unsigned RES_W     = 17,
    parameter int unsigned STORE_W   = 16
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       write,
    input  logic                       read,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       beginbursttransfer,
    input  logic [BURST_W-1:0]         burstcount,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    output logic [1:0]                 response,
    output logic                       waitrequest,
    output logic [ADDR_W-1:0]          pix_addr,
    output logic                       pix_wen,
    output logic [ADDR_W-1:0]          wgt_addr,
    output logic                       wgt_wen,
    output logic [STORE_W-1:0]         store_data,
    output logic [$clog2(NUM_RES)-1:0] res_sel,
    input  logic [RES_W-1:0]           res_data,
    input  logic                       done_calc,
    output logic                       start_calc,
    output logic                       irq
);

    localparam int unsigned SelW    = $clog2(NUM_RES);
    localparam int unsigned WgtBase = wgt_base(PIX_DEPTH);
    localparam int unsigned ResBase = res_base(PIX_DEPTH, WGT_DEPTH);

    bus_state_e state_q, state_d;

    logic               cnt_load;
    logic               cnt_skip_first;
    logic               cnt_step;
    logic [ADDR_W-1:0]  beat_addr;
    logic               last_beat;

    logic               wr_beat;
    logic [ADDR_W-1:0]  wr_addr;
    logic               rd_beat;
    region_e            wr_region;
    region_e            rd_region;
    logic               csr_wr;
    logic               start_fire;
    logic [DATA_W-1:0]  csr_rdata;

    logic               pix_wen_q, pix_wen_d;
    logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
    logic               wgt_wen_q, wgt_wen_d;
    logic [ADDR_W-1:0]  wgt_addr_q, wgt_addr_d;
    logic [STORE_W-1:0] store_data_q, store_data_d;
    logic               start_calc_q, start_calc_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               irq_q, irq_d;

    // beginbursttransfer is informational; upper writedata bits are unused.
    logic unused_inputs;
    assign unused_inputs = ^{beginbursttransfer, writedata};

    avalon_burst_counter #(
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) u_counter (
        .clk             (clk),
        .n_rst           (n_rst),
        .load            (cnt_load),
        .load_skip_first (cnt_skip_first),
        .load_base       (address),
        .load_beats      (burstcount),
        .step            (cnt_step),
        .beat_addr       (beat_addr),
        .last_beat       (last_beat)
    );

    // Burst FSM: decides which beat (if any) is performed this cycle.
    always_comb begin
        state_d        = state_q;
        cnt_load       = 1'b0;
        cnt_skip_first = 1'b0;
        cnt_step       = 1'b0;
        wr_beat        = 1'b0;
        wr_addr        = '0;
        rd_beat        = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Write wins over a simultaneous read.
                if (write) begin
                    wr_beat        = 1'b1;
                    wr_addr        = address;
                    cnt_load       = 1'b1;
                    cnt_skip_first = 1'b1;
                    if (burstcount > BURST_W'(1)) begin
                        state_d = StWburst;
                    end
                end else if (read) begin
                    cnt_load = 1'b1;
                    state_d  = StRburst;
                end
            end
            StWburst: begin
                // write low is a bubble: no beat, no index advance.
                if (write) begin
                    wr_beat = 1'b1;
                    wr_addr = beat_addr;
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_step = 1'b1;
                    end
                end
            end
            StRburst: begin
                rd_beat = 1'b1;
                if (last_beat) begin
                    state_d = StIdle;
                end else begin
                    cnt_step = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign waitrequest = (state_q == StRburst);
    assign wr_region   = decode_region(32'(wr_addr), PIX_DEPTH, WGT_DEPTH, NUM_RES);
    assign rd_region   = decode_region(32'(beat_addr), PIX_DEPTH, WGT_DEPTH, NUM_RES);

    // Write side effects, registered so enables are clean single-cycle pulses.
    always_comb begin
        pix_wen_d    = wr_beat && (wr_region == RegionPix);
        wgt_wen_d    = wr_beat && (wr_region == RegionWgt);
        pix_addr_d   = pix_wen_d ? wr_addr : pix_addr_q;
        wgt_addr_d   = wgt_wen_d ? ADDR_W'(32'(wr_addr) - WgtBase) : wgt_addr_q;
        store_data_d = (pix_wen_d || wgt_wen_d) ? writedata[STORE_W-1:0] : store_data_q;
    end

    // CSR: START pulses only when idle; DONE set beats W1C; START beats done_calc on BUSY.
    always_comb begin
        csr_wr       = wr_beat && (wr_region == RegionCsr);
        start_fire   = csr_wr && writedata[CsrStartBit] && !busy_q;
        start_calc_d = start_fire;
        irq_en_d     = csr_wr ? writedata[CsrIrqEnBit] : irq_en_q;
        busy_d       = busy_q;
        if (start_fire) begin
            busy_d = 1'b1;
        end else if (done_calc) begin
            busy_d = 1'b0;
        end
        done_d = done_q;
        if (done_calc) begin
            done_d = 1'b1;
        end else if (csr_wr && writedata[CsrDoneBit]) begin
            done_d = 1'b0;
        end
        irq_d = done_q && irq_en_q;
    end

    always_comb begin
        csr_rdata              = '0;
        csr_rdata[CsrIrqEnBit] = irq_en_q;
        csr_rdata[CsrDoneBit]  = done_q;
        csr_rdata[CsrBusyBit]  = busy_q;
    end

    // Read beat: decoded independently per beat, so bursts may cross regions.
    always_comb begin
        readdatavalid = rd_beat;
        readdata      = '0;
        response      = RespOkay;
        res_sel       = '0;
        if (rd_beat) begin
            unique case (rd_region)
                RegionPix, RegionWgt: response = RespSlvErr;
                RegionRes: begin
                    res_sel  = SelW'(32'(beat_addr) - ResBase);
                    readdata = DATA_W'(res_data);
                end
                RegionCsr: readdata = csr_rdata;
                default:   response = RespDecodeErr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            pix_wen_q    <= 1'b0;
            pix_addr_q   <= '0;
            wgt_wen_q    <= 1'b0;
            wgt_addr_q   <= '0;
            store_data_q <= '0;
            start_calc_q <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_wen_q    <= pix_wen_d;
            pix_addr_q   <= pix_addr_d;
            wgt_wen_q    <= wgt_wen_d;
            wgt_addr_q   <= wgt_addr_d;
            store_data_q <= store_data_d;
            start_calc_q <= start_calc_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            irq_q        <= irq_d;
        end
    end

    assign pix_wen    = pix_wen_q;
    assign pix_addr   = pix_addr_q;
    assign wgt_wen    = wgt_wen_q;
    assign wgt_addr   = wgt_addr_q;
    assign store_data = store_data_q;
    assign start_calc = start_calc_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_avalon_burst_slave.sv
module tb_avalon_burst_slave;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned BURST_W   = 10;
    localparam int unsigned PIX_DEPTH = 784;
    localparam int unsigned WGT_DEPTH = 784;
    localparam int unsigned NUM_RES   = 10;
    localparam int unsigned RES_W     = 17;
    localparam int unsigned STORE_W   = 16;
    localparam int unsigned SelW      = $clog2(NUM_RES);
    localparam logic [10:0] CsrAddr   = 11'd1578;

    logic                clk;
    logic                n_rst;
    logic [ADDR_W-1:0]   address;
    logic                write;
    logic                read;
    logic [DATA_W-1:0]   writedata;
    logic                beginbursttransfer;
    logic [BURST_W-1:0]  burstcount;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic [1:0]          response;
    logic                waitrequest;
    logic [ADDR_W-1:0]   pix_addr;
    logic                pix_wen;
    logic [ADDR_W-1:0]   wgt_addr;
    logic                wgt_wen;
    logic [STORE_W-1:0]  store_data;
    logic [SelW-1:0]     res_sel;
    logic [RES_W-1:0]    res_data;
    logic                done_calc;
    logic                start_calc;
    logic                irq;

    avalon_burst_slave #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_W   (BURST_W),
        .PIX_DEPTH (PIX_DEPTH),
        .WGT_DEPTH (WGT_DEPTH),
        .NUM_RES   (NUM_RES),
        .RES_W     (RES_W),
        .STORE_W   (STORE_W)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .address            (address),
        .write              (write),
        .read               (read),
        .writedata          (writedata),
        .beginbursttransfer (beginbursttransfer),
        .burstcount         (burstcount),
        .readdata           (readdata),
        .readdatavalid      (readdatavalid),
        .response           (response),
        .waitrequest        (waitrequest),
        .pix_addr           (pix_addr),
        .pix_wen            (pix_wen),
        .wgt_addr           (wgt_addr),
        .wgt_wen            (wgt_wen),
        .store_data         (store_data),
        .res_sel            (res_sel),
        .res_data           (res_data),
        .done_calc          (done_calc),
        .start_calc         (start_calc),
        .irq                (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        sel_chk;
        logic [3:0]  sel;
    } rd_exp_t;

    typedef struct packed {
        logic        is_wgt;
        logic [10:0] addr;
        logic [15:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic        wr;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [1:0]  exp_kind;   // 0 none, 1 pixel, 2 weight
        logic [10:0] exp_waddr;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        sel_chk;
        logic [3:0]  exp_sel;
    } vec_t;

    rd_exp_t     rq[$];
    wr_exp_t     wq[$];
    logic [31:0] exp_csr;
    vec_t        vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_rd(input logic [10:0] a);
        rd_exp_t e;
        e.data    = '0;
        e.resp    = 2'b00;
        e.sel_chk = 1'b0;
        e.sel     = '0;
        if (32'(a) < 32'd1568) begin
            e.resp = 2'b10;
        end else if (32'(a) < 32'd1578) begin
            e.data    = 32'(res_data);
            e.sel_chk = 1'b1;
            e.sel     = 4'(32'(a) - 32'd1568);
        end else if (a == CsrAddr) begin
            e.data = exp_csr;
        end else begin
            e.resp = 2'b11;
        end
        rq.push_back(e);
    endfunction

    function automatic void push_wr(input logic [10:0] a, input logic [31:0] d);
        wr_exp_t e;
        e.data = d[15:0];
        if (32'(a) < 32'd784) begin
            e.is_wgt = 1'b0;
            e.addr   = a;
            wq.push_back(e);
        end else if (32'(a) < 32'd1568) begin
            e.is_wgt = 1'b1;
            e.addr   = a - 11'd784;
            wq.push_back(e);
        end
    endfunction

    // Scoreboard monitor: compares every produced beat / enable with the queues.
    always @(negedge clk) begin : mon
        rd_exp_t re;
        wr_exp_t we;
        if (n_rst) begin
            if (readdatavalid) begin
                if (rq.size() == 0) begin
                    check("unexpected_valid", 32'(readdatavalid), 32'd0);
                end else begin
                    re = rq.pop_front();
                    check("rd_data", readdata, re.data);
                    check("rd_resp", 32'(response), 32'(re.resp));
                    if (re.sel_chk) check("res_sel", 32'(res_sel), 32'(re.sel));
                end
            end else begin
                check("resp_no_valid", 32'(response), 32'd0);
            end
            if (pix_wen || wgt_wen) begin
                if (wq.size() == 0) begin
                    check("unexpected_wen", 32'({pix_wen, wgt_wen}), 32'd0);
                end else begin
                    we = wq.pop_front();
                    check("wen_is_wgt", 32'(wgt_wen), 32'(we.is_wgt));
                    check("wen_one_hot", 32'(pix_wen && wgt_wen), 32'd0);
                    check("wen_addr", 32'(we.is_wgt ? wgt_addr : pix_addr), 32'(we.addr));
                    check("store_data", 32'(store_data), 32'(we.data));
                end
            end
        end
    end

    // Drives one write burst; optional bubble of gap_len cycles before beat gap_at.
    task automatic wr_burst(input logic [10:0] a, input int n, input logic [31:0] d0,
                            input int gap_at, input int gap_len, input bit push);
        logic [10:0] ba;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                write = 1'b0;
                beginbursttransfer = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    if (g > 0) begin
                        check("gap_pix_wen", 32'(pix_wen), 32'd0);
                        check("gap_wgt_wen", 32'(wgt_wen), 32'd0);
                    end
                    @(posedge clk); #1;
                end
            end
            ba = a + 11'(i);
            write = 1'b1;
            address = ba;
            writedata = d0 + 32'(i);
            burstcount = BURST_W'(n);
            beginbursttransfer = (i == 0);
            if (push) push_wr(ba, d0 + 32'(i));
            check("wr_waitreq", 32'(waitrequest), 32'd0);
            @(posedge clk); #1;
        end
        write = 1'b0;
        beginbursttransfer = 1'b0;
    endtask

    task automatic rd_burst(input logic [10:0] a, input int n, input bit push);
        read = 1'b1;
        address = a;
        burstcount = BURST_W'(n);
        beginbursttransfer = 1'b1;
        if (push) for (int i = 0; i < n; i++) push_rd(a + 11'(i));
        check("rd_accept_waitreq", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        read = 1'b0;
        beginbursttransfer = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rd_valid", 32'(readdatavalid), 32'd1);
            check("rd_waitreq", 32'(waitrequest), 32'd1);
        end
        @(negedge clk);
        check("rd_valid_end", 32'(readdatavalid), 32'd0);
        check("rd_end_waitreq", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        vec_t    v;
        rd_exp_t re;
        wr_exp_t we;
        n_rst = 1'b0;
        address = '0;
        write = 1'b0;
        read = 1'b0;
        writedata = '0;
        beginbursttransfer = 1'b0;
        burstcount = '0;
        res_data = 17'h1ABCD;
        done_calc = 1'b0;
        exp_csr = '0;

        vecs[0]  = '{1'b1, 11'd0,    32'hDEAD0011, 2'd1, 11'd0,   32'd0,      2'b00, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 11'd783,  32'h00001234, 2'd1, 11'd783, 32'd0,      2'b00, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 11'd784,  32'h00005555, 2'd2, 11'd0,   32'd0,      2'b00, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 11'd1567, 32'h00070007, 2'd2, 11'd783, 32'd0,      2'b00, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 11'd1568, 32'h00000099, 2'd0, 11'd0,   32'd0,      2'b00, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, 11'd2000, 32'h00000001, 2'd0, 11'd0,   32'd0,      2'b00, 1'b0, 4'd0};
        vecs[6]  = '{1'b0, 11'd0,    32'd0,        2'd0, 11'd0,   32'd0,      2'b10, 1'b0, 4'd0};
        vecs[7]  = '{1'b0, 11'd1000, 32'd0,        2'd0, 11'd0,   32'd0,      2'b10, 1'b0, 4'd0};
        vecs[8]  = '{1'b0, 11'd1568, 32'd0,        2'd0, 11'd0,   32'h1ABCD,  2'b00, 1'b1, 4'd0};
        vecs[9]  = '{1'b0, 11'd1577, 32'd0,        2'd0, 11'd0,   32'h1ABCD,  2'b00, 1'b1, 4'd9};
        vecs[10] = '{1'b0, 11'd1578, 32'd0,        2'd0, 11'd0,   32'd0,      2'b00, 1'b0, 4'd0};
        vecs[11] = '{1'b0, 11'd1579, 32'd0,        2'd0, 11'd0,   32'd0,      2'b11, 1'b0, 4'd0};
        vecs[12] = '{1'b0, 11'd2047, 32'd0,        2'd0, 11'd0,   32'd0,      2'b11, 1'b0, 4'd0};

        // Reset values
        #3;
        check("rst_valid", 32'(readdatavalid), 32'd0);
        check("rst_pix_wen", 32'(pix_wen), 32'd0);
        check("rst_wgt_wen", 32'(wgt_wen), 32'd0);
        check("rst_start", 32'(start_calc), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_resp", 32'(response), 32'd0);
        check("rst_waitreq", 32'(waitrequest), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven single-beat accesses
        for (int k = 0; k < 13; k++) begin
            v = vecs[k];
            if (v.wr) begin
                if (v.exp_kind != 2'd0) begin
                    we.is_wgt = (v.exp_kind == 2'd2);
                    we.addr   = v.exp_waddr;
                    we.data   = v.wdata[15:0];
                    wq.push_back(we);
                end
                wr_burst(v.addr, 1, v.wdata, -1, 0, 1'b0);
            end else begin
                re.data    = v.exp_rdata;
                re.resp    = v.exp_resp;
                re.sel_chk = v.sel_chk;
                re.sel     = v.exp_sel;
                rq.push_back(re);
                rd_burst(v.addr, 1, 1'b0);
            end
        end

        // Write burst crossing pixel -> weight
        wr_burst(11'd782, 4, 32'd1, -1, 0, 1'b1);
        // Write burst with a 2-cycle bubble before beat 2
        wr_burst(11'd300, 4, 32'h0000ABC0, 2, 2, 1'b1);
        // Read burst crossing weight -> results
        rd_burst(11'd1566, 4, 1'b1);
        // Read CSR then unmapped
        rd_burst(CsrAddr, 2, 1'b1);
        // Address wrap
        rd_burst(11'd2046, 3, 1'b1);

        // CSR: START + IRQ_EN
        wr_burst(CsrAddr, 1, 32'h3, -1, 0, 1'b0);
        @(negedge clk); check("start_pulse", 32'(start_calc), 32'd1);
        @(negedge clk); check("start_pulse_end", 32'(start_calc), 32'd0);
        @(posedge clk); #1;
        exp_csr = 32'hA;
        rd_burst(CsrAddr, 1, 1'b1);
        // START while BUSY is ignored
        wr_burst(CsrAddr, 1, 32'h3, -1, 0, 1'b0);
        @(negedge clk); check("start_ignored0", 32'(start_calc), 32'd0);
        @(negedge clk); check("start_ignored1", 32'(start_calc), 32'd0);
        @(posedge clk); #1;
        // done_calc -> DONE, BUSY clear, irq one cycle later
        done_calc = 1'b1;
        @(posedge clk); #1;
        done_calc = 1'b0;
        @(negedge clk); check("irq_lag", 32'(irq), 32'd0);
        @(negedge clk); check("irq_set", 32'(irq), 32'd1);
        @(posedge clk); #1;
        exp_csr = 32'h6;
        rd_burst(CsrAddr, 1, 1'b1);
        // W1C DONE keeping IRQ_EN
        wr_burst(CsrAddr, 1, 32'h6, -1, 0, 1'b0);
        @(negedge clk); check("irq_hold", 32'(irq), 32'd1);
        @(negedge clk); check("irq_clr", 32'(irq), 32'd0);
        @(posedge clk); #1;
        exp_csr = 32'h2;
        rd_burst(CsrAddr, 1, 1'b1);
        // START coinciding with done_calc while idle
        done_calc = 1'b1;
        wr_burst(CsrAddr, 1, 32'h1, -1, 0, 1'b0);
        done_calc = 1'b0;
        @(negedge clk); check("start_with_done", 32'(start_calc), 32'd1);
        @(posedge clk); #1;
        exp_csr = 32'hC;
        rd_burst(CsrAddr, 1, 1'b1);
        // DONE set wins over W1C
        done_calc = 1'b1;
        wr_burst(CsrAddr, 1, 32'h4, -1, 0, 1'b0);
        done_calc = 1'b0;
        exp_csr = 32'h4;
        rd_burst(CsrAddr, 1, 1'b1);
        wr_burst(CsrAddr, 1, 32'h4, -1, 0, 1'b0);
        exp_csr = 32'h0;
        rd_burst(CsrAddr, 1, 1'b1);

        // Reset during beat 2 of an 8-beat read
        wr_burst(CsrAddr, 1, 32'h2, -1, 0, 1'b0);
        push_rd(11'd0);
        push_rd(11'd1);
        read = 1'b1;
        address = 11'd0;
        burstcount = BURST_W'(8);
        @(posedge clk); #1;
        read = 1'b0;
        @(negedge clk); check("pre_rst_valid0", 32'(readdatavalid), 32'd1);
        @(negedge clk); check("pre_rst_valid1", 32'(readdatavalid), 32'd1);
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(readdatavalid), 32'd0);
        check("mid_rst_resp", 32'(response), 32'd0);
        check("mid_rst_waitreq", 32'(waitrequest), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_valid", 32'(readdatavalid), 32'd0);
        end
        @(posedge clk); #1;
        exp_csr = 32'h0;
        rd_burst(CsrAddr, 1, 1'b1);
        rd_burst(11'd0, 1, 1'b1);
        check("post_rst_irq", 32'(irq), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_left", 32'(rq.size()), 32'd0);
        check("wr_queue_left", 32'(wq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/avalon_burst_slave.md
AVALON_BURST_SLAVE -- requirements
Module: avalon_burst_slave

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DATA_W, 32, bus data width.
- ADDR_W, 11, word address width.
- BURST_W, 10, burstcount width.
- PIX_DEPTH, 784, pixel words.
- WGT_DEPTH, 784, weight words.
- NUM_RES, 10, result words.
- RES_W, 17, result width (RES_W <= DATA_W).
- STORE_W, 16, memory store width.
REQ-002 SHALL have these ports (name, direction, width, meaning); reset n_rst is asynchronous, active-low; clock is clk:
- clk  in  1  clock.
- n_rst  in  1  async active-low reset.
- address  in  ADDR_W  word address.
- write  in  1  write request.
- read  in  1  read request.
- writedata  in  DATA_W  write data.
- beginbursttransfer  in  1  burst start marker (informational only).
- burstcount  in  BURST_W  beats.
- readdata  out  DATA_W  read data.
- readdatavalid  out  1  read beat valid.
- response  out  2  beat status.
- waitrequest  out  1  stall.
- pix_addr  out  ADDR_W  pixel write address.
- pix_wen  out  1  pixel write enable.
- wgt_addr  out  ADDR_W  weight write address.
- wgt_wen  out  1  weight write enable.
- store_data  out  STORE_W  writedata[STORE_W-1:0].
- res_sel  out  $clog2(NUM_RES)  result index.
- res_data  in  RES_W  selected result.
- done_calc  in  1  core finished, level.
- start_calc  out  1  one-cycle start pulse.
- irq  out  1  interrupt.

Function
REQ-003 SHALL decode the address map as:
- Pixels: [0, PIX_DEPTH).
- Weights: [PIX_DEPTH, PIX_DEPTH+WGT_DEPTH).
- Results: next NUM_RES words.
- CSR: the single following word.
- Anything above: unmapped.
REQ-004 SHALL run FSM states IDLE, WBURST and RBURST.
REQ-005 IDLE: waitrequest=0; write latches base=address and beats=max(burstcount,1), performs beat 0, then goes to WBURST if beats>1, else stays in IDLE.
REQ-006 WBURST: waitrequest=0; each write-high cycle performs beat i at base+i; write low inserts a bubble with no side effect; return to IDLE after the last beat.
REQ-007 Read in IDLE SHALL be accepted with waitrequest=0 that cycle, latch base and beats, and enter RBURST.
REQ-008 RBURST behaviour:
- waitrequest=1 throughout.
- readdatavalid=1 for exactly beats consecutive cycles, starting the cycle after acceptance.
- Beat i returns data for base+i.
- Return to IDLE in the cycle the last beat is driven.
REQ-009 Beat address SHALL wrap modulo 2^ADDR_W; each beat is decoded independently, so bursts may cross regions.
REQ-010 Pixel write SHALL assert pix_wen for one cycle, with pix_addr=beat address and store_data=writedata[STORE_W-1:0].
REQ-011 Weight write SHALL assert wgt_wen for one cycle, with wgt_addr=beat address-PIX_DEPTH.
REQ-012 Results SHALL be read-only: res_sel=beat address-result base, readdata=zero-extended res_data, response=2'b00.
REQ-013 Read of pixel/weight regions SHALL return readdata=0, response=2'b10 (SLVERR).
REQ-014 Unmapped read SHALL return readdata=0, response=2'b11 (DECODEERROR).
REQ-015 Writes to results or unmapped addresses SHALL be silently dropped.
REQ-016 CSR bits:
- bit0 START: write 1 -> start_calc=1 next cycle for one cycle; reads 0.
- bit1 IRQ_EN: read/write.
- bit2 DONE: sticky; set on any cycle done_calc=1; write 1 clears it.
- bit3 BUSY: read-only.
- Other bits read 0.
REQ-017 BUSY SHALL set with the start_calc pulse and clear when done_calc=1.
REQ-018 START written while BUSY=1 SHALL be ignored (no pulse).
REQ-019 If DONE set and W1C clear coincide, set SHALL win; if done_calc and START coincide while BUSY=0, BUSY ends at 1 and DONE at 1.
REQ-020 irq SHALL be registered: irq = DONE & IRQ_EN, one cycle after either bit changes.
REQ-021 read and write asserted together in IDLE: write SHALL take priority and the read is ignored.
REQ-022 response SHALL be 2'b00 whenever readdatavalid=0.

Reset
REQ-023 On n_rst low, asynchronously: state=IDLE, counters=0, CSR=0, and all outputs 0 (readdatavalid, pix_wen, wgt_wen, start_calc, irq, readdata, response).
REQ-024 Reset mid-burst SHALL abort the burst with no further beats or enables after release.

Structure
REQ-025 Package nn_bus_pkg SHALL hold:
- The state enum.
- Response codes OKAY/SLVERR/DECODEERROR.
- CSR bit indices.
- Region-base localparam functions of PIX_DEPTH/WGT_DEPTH/NUM_RES.
REQ-026 Sub-module avalon_burst_counter SHALL hold base latch, beat index and last-beat flag, shared by WBURST and RBURST.

Verification
REQ-027 Default parameters SHALL be used, giving weights base 784, results 1568, CSR 1578.
REQ-028 Directed scenarios a bench must cover:
- Write burst at 782, burstcount 4, data 1..4 -> pix_wen at 782, 783; wgt_wen at wgt_addr 0, 1; store_data 1..4.
- Write burst with write deasserted mid-burst for 2 cycles -> no enables during the gap; all beats still written.
- Read at 1566, burstcount 4, res_data=17'h1ABCD -> 4 consecutive valids: 0/SLVERR, 0/SLVERR, 0x1ABCD/OKAY with res_sel 0, 0x1ABCD/OKAY with res_sel 1.
- Read at 1578, burstcount 2 -> CSR value/OKAY, then 0/DECODEERROR.
- Write CSR 0x3 -> start_calc pulse; BUSY=1; second START ignored; done_calc -> DONE=1, BUSY=0; irq high next cycle; write 0x6 clears DONE, irq drops.
- Assert n_rst during RBURST beat 2 of 8 -> readdatavalid 0; after release, new single read at 0 returns SLVERR.
